mem_lsu: RTL and testbench

Parametrised load/store unit for the MEM stage of the five-stage MIPS pipeline. It replaces the single-cycle memory path with an SRAM-like request/acknowledge bus, a posted write buffer of configurable depth and a pipeline stall output. It also performs byte-lane selection, load sign/zero extension and address-alignment checks. Alignment results (adel/ades/bad_addr) feed the exception/CP0 logic in the same stage.

---
 rtl/lsu_pkg.sv | 110 +++++++++++
 rtl/lsu_wbuf.sv | 76 +++++++
 rtl/mem_lsu.sv | 199 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: opcodes, access sizes,
// FSM states, the write-buffer entry layout and lane/extension helpers.
package lsu_pkg;

   // MIPS memory opcodes as they appear in the MEM stage
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   // Bus access size encodings
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WB_REQ  = 3'd1,
      ST_WB_WAIT = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_RD_DROP = 3'd5
   } lsu_state_e;

   // One posted store, already lane-positioned
   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] data;
   } wb_entry_t;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic [1:0] op_size(input logic [5:0] op);
      logic [1:0] sz;
      case (op)
         OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
         default:              sz = SZ_WORD;
      endcase
      return sz;
   endfunction

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
      logic ok;
      case (size)
         SZ_HALF: ok = ~off[0];
         SZ_WORD: ok = (off == 2'b00);
         default: ok = 1'b1;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] s;
      case (size)
         SZ_BYTE: s = 4'b0001 << off;
         SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   // Replicate right-aligned store data so every enabled lane carries it
   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] d;
      case (size)
         SZ_BYTE: d = {4{wdata[7:0]}};
         SZ_HALF: d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   // Select the addressed byte/half of a read word and extend it per opcode
   function automatic logic [31:0] load_ext(input logic [5:0] op, input logic [1:0] off,
                                            input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         OP_LB:   r = {{24{b[7]}}, b};
         OP_LBU:  r = {24'h000000, b};
         OP_LH:   r = {{16{h[15]}}, h};
         OP_LHU:  r = {16'h0000, h};
         default: r = rdata;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_wbuf.sv
// Posted write buffer: synchronous FIFO with power-of-two depth. A pop and a
// push in the same cycle are both honoured even when the FIFO is full.
module lsu_wbuf #(
   parameter int DEPTH = 4,
   parameter int W     = 70
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int              PW       = $clog2(DEPTH);
   localparam int              MASK_INT = DEPTH - 1;
   localparam logic [PW-1:0]   PTR_MASK = MASK_INT[PW-1:0];
   localparam logic [PW:0]     CNT_FULL = DEPTH[PW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];

   // Next pointer/occupancy, wrapping pointers by masking to the depth
   always_comb begin
      do_pop   = pop_i & ~empty_o;
      do_push  = push_i & (~full_o | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q + 1'b1) & PTR_MASK;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q + 1'b1) & PTR_MASK;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: alignment checks, posted store buffer, a single
// outstanding request/acknowledge bus transaction and pipeline stall control.
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int WB_DEPTH = 4,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic [5:0]        mem_op,
   input  logic [31:0]       mem_aluout,
   input  logic [31:0]       mem_wdata,
   input  logic              flush,
   output logic              mem_stall,
   output logic [31:0]       mem_result,
   output logic              mem_rvalid,
   output logic              adel,
   output logic              ades,
   output logic [31:0]       bad_addr,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [3:0]        data_wstrb,
   output logic [31:0]       data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [31:0]       data_rdata
);

   localparam int EW = $bits(wb_entry_t);

   lsu_state_e          state_q, state_d;
   logic [31:0]         bus_addr_q, bus_addr_d;
   logic [1:0]          bus_size_q, bus_size_d;
   logic [3:0]          bus_strb_q, bus_strb_d;
   logic [31:0]         bus_wdata_q, bus_wdata_d;
   logic [5:0]          rd_op_q, rd_op_d;
   logic [1:0]          rd_off_q, rd_off_d;

   logic                acc_ld, acc_st, acc_aligned;
   logic [1:0]          acc_size;
   logic                load_ok, store_ok;
   logic                wb_push, wb_pop, wb_full, wb_empty;
   wb_entry_t           push_entry, head_entry;
   logic [EW-1:0]       head_raw;
   logic [ADDR_W+31:0]  addr_ext;

   // Decode of the instruction currently in MEM
   assign acc_ld      = is_load(mem_op);
   assign acc_st      = is_store(mem_op);
   assign acc_size    = op_size(mem_op);
   assign acc_aligned = is_aligned(acc_size, mem_aluout[1:0]);

   // Alignment exceptions are reported combinationally to CP0 in this stage
   assign adel     = mem_valid & acc_ld & ~acc_aligned;
   assign ades     = mem_valid & acc_st & ~acc_aligned;
   assign bad_addr = (adel | ades) ? mem_aluout : 32'h0000_0000;

   assign load_ok  = mem_valid & ~flush & acc_ld & acc_aligned;
   assign store_ok = mem_valid & ~flush & acc_st & acc_aligned;

   // A completed write response retires the head entry, freeing a slot this cycle
   assign wb_pop     = (state_q == ST_WB_WAIT) & data_data_ok;
   assign wb_push    = store_ok & (~wb_full | wb_pop);
   assign mem_rvalid = (state_q == ST_RD_WAIT) & data_data_ok & ~flush;
   assign mem_stall  = (load_ok & ~mem_rvalid) | (store_ok & wb_full & ~wb_pop);
   assign mem_result = mem_rvalid ? load_ext(rd_op_q, rd_off_q, data_rdata) : 32'h0000_0000;

   assign push_entry.addr  = mem_aluout;
   assign push_entry.size  = acc_size;
   assign push_entry.wstrb = lane_strb(acc_size, mem_aluout[1:0]);
   assign push_entry.data  = lane_data(acc_size, mem_wdata);
   assign head_entry       = wb_entry_t'(head_raw);

   lsu_wbuf #(
      .DEPTH (WB_DEPTH),
      .W     (EW)
   ) u_wbuf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (wb_push),
      .push_data_i (push_entry),
      .pop_i       (wb_pop),
      .full_o      (wb_full),
      .empty_o     (wb_empty),
      .head_o      (head_raw)
   );

   // Bus signals come only from registered state so they stay put until accepted
   assign addr_ext   = {{ADDR_W{1'b0}}, bus_addr_q};
   assign data_req   = (state_q == ST_WB_REQ) | (state_q == ST_RD_REQ);
   assign data_wr    = (state_q == ST_WB_REQ);
   assign data_size  = bus_size_q;
   assign data_addr  = addr_ext[ADDR_W-1:0];
   assign data_wstrb = bus_strb_q;
   assign data_wdata = bus_wdata_q;

   // Next-state and bus-field capture; stores drain before any load is issued
   always_comb begin
      state_d     = state_q;
      bus_addr_d  = bus_addr_q;
      bus_size_d  = bus_size_q;
      bus_strb_d  = bus_strb_q;
      bus_wdata_d = bus_wdata_q;
      rd_op_d     = rd_op_q;
      rd_off_d    = rd_off_q;
      case (state_q)
         ST_IDLE: begin
            if (!wb_empty) begin
               state_d     = ST_WB_REQ;
               bus_addr_d  = (head_entry.size == SZ_WORD) ?
                             {head_entry.addr[31:2], 2'b00} : head_entry.addr;
               bus_size_d  = head_entry.size;
               bus_strb_d  = head_entry.wstrb;
               bus_wdata_d = head_entry.data;
            end else if (load_ok) begin
               state_d     = ST_RD_REQ;
               bus_addr_d  = (acc_size == SZ_WORD) ?
                             {mem_aluout[31:2], 2'b00} : mem_aluout;
               bus_size_d  = acc_size;
               bus_strb_d  = 4'b0000;
               bus_wdata_d = 32'h0000_0000;
               rd_op_d     = mem_op;
               rd_off_d    = mem_aluout[1:0];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WB_REQ: begin
            if (data_addr_ok) begin
               state_d = ST_WB_WAIT;
            end else begin
               state_d = ST_WB_REQ;
            end
         end
         ST_WB_WAIT: begin
            if (data_data_ok) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WB_WAIT;
            end
         end
         ST_RD_REQ: begin
            if (data_addr_ok) begin
               // A flushed load already accepted must still consume its response
               state_d = flush ? ST_RD_DROP : ST_RD_WAIT;
            end else if (flush) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RD_REQ;
            end
         end
         ST_RD_WAIT: begin
            if (data_data_ok) begin
               state_d = ST_IDLE;
            end else if (flush) begin
               state_d = ST_RD_DROP;
            end else begin
               state_d = ST_RD_WAIT;
            end
         end
         ST_RD_DROP: begin
            if (data_data_ok) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RD_DROP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and captured transaction registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bus_addr_q  <= 32'h0000_0000;
         bus_size_q  <= 2'b00;
         bus_strb_q  <= 4'b0000;
         bus_wdata_q <= 32'h0000_0000;
         rd_op_q     <= 6'b000000;
         rd_off_q    <= 2'b00;
      end else begin
         state_q     <= state_d;
         bus_addr_q  <= bus_addr_d;
         bus_size_q  <= bus_size_d;
         bus_strb_q  <= bus_strb_d;
         bus_wdata_q <= bus_wdata_d;
         rd_op_q     <= rd_op_d;
         rd_off_q    <= rd_off_d;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a hand-driven or automatic bus slave.
module tb_mem_lsu;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, flush;
   logic [5:0]  mem_op;
   logic [31:0] mem_aluout, mem_wdata;
   logic        mem_stall, mem_rvalid, adel, ades;
   logic [31:0] mem_result, bad_addr;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } bus_rec_t;

   bus_rec_t    log_q[$];
   logic        auto_slave;
   logic [31:0] slave_rdata;
   logic        acc_prev;
   int          n_chk;
   int          n_fail;

   always #5 clk = ~clk;

   mem_lsu #(.WB_DEPTH(4), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_op(mem_op),
      .mem_aluout(mem_aluout), .mem_wdata(mem_wdata), .flush(flush),
      .mem_stall(mem_stall), .mem_result(mem_result), .mem_rvalid(mem_rvalid),
      .adel(adel), .ades(ades), .bad_addr(bad_addr), .data_req(data_req),
      .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one cycle: log any bus acceptance, then drive the slave if automatic
   task automatic tick();
      bus_rec_t r;
      logic acc;
      acc = data_req & data_addr_ok;
      if (acc) begin
         r.wr = data_wr; r.addr = data_addr; r.strb = data_wstrb; r.wdata = data_wdata;
         log_q.push_back(r);
      end
      @(posedge clk);
      #1;
      if (auto_slave) begin
         data_data_ok = acc;
         data_addr_ok = acc ? 1'b0 : data_req;
         data_rdata   = slave_rdata;
      end
      acc_prev = acc;
   endtask

   task automatic idle_inputs();
      mem_valid = 1'b0; flush = 1'b0; mem_op = 6'b000000;
      mem_aluout = 32'h0; mem_wdata = 32'h0;
   endtask

   // Manual-slave load: addr_ok in cycle 1, data_ok in cycle 3
   task automatic load_txn(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
      tick(); mem_valid = 1'b1; mem_op = op; mem_aluout = addr;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
      check_val({tag, "_stall_c0"}, {31'd0, mem_stall}, 32'd1);
      tick(); data_addr_ok = 1'b1; #1;
      check_val({tag, "_req_c1"}, {31'd0, data_req}, 32'd1);
      check_val({tag, "_addr_c1"}, data_addr, addr);
      tick(); data_addr_ok = 1'b0; #1;
      check_val({tag, "_stall_c2"}, {31'd0, mem_stall}, 32'd1);
      tick(); data_data_ok = 1'b1; data_rdata = rdata; #1;
      check_val({tag, "_rvalid_c3"}, {31'd0, mem_rvalid}, 32'd1);
      check_val({tag, "_stall_c3"}, {31'd0, mem_stall}, 32'd0);
      check_val({tag, "_result"}, mem_result, exp);
      tick(); data_data_ok = 1'b0; idle_inputs(); #1;
      check_val({tag, "_rvalid_after"}, {31'd0, mem_rvalid}, 32'd0);
   endtask

   // Run the automatic slave until the log holds n records or the budget expires
   task automatic drain_until(input string tag, input int n);
      for (int i = 0; i < 80 && log_q.size() < n; i++) begin
         tick(); #1;
      end
      check_val({tag, "_count"}, log_q.size(), n);
   endtask

   logic [31:0] sb_addr [5] = '{32'h4002, 32'h4000, 32'h4001, 32'h4003, 32'h4000};
   logic [7:0]  sb_byte [5] = '{8'hAB, 8'h11, 8'h22, 8'h33, 8'h44};
   logic [3:0]  sb_strb [5] = '{4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
   logic [31:0] sb_data [5] = '{32'hABABABAB, 32'h11111111, 32'h22222222,
                                32'h33333333, 32'h44444444};
   logic [31:0] sb_stall = 32'b10000;

   initial begin
      logic got;
      logic [31:0] res;
      n_chk = 0; n_fail = 0;
      auto_slave = 1'b0; slave_rdata = 32'h0; acc_prev = 1'b0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check_val("rst_stall", {31'd0, mem_stall}, 32'd0);
      check_val("rst_rvalid", {31'd0, mem_rvalid}, 32'd0);
      check_val("rst_result", mem_result, 32'd0);
      check_val("rst_exc", {30'd0, adel, ades}, 32'd0);
      check_val("rst_bad_addr", bad_addr, 32'd0);
      check_val("rst_req", {31'd0, data_req}, 32'd0);

      // Loads with extension
      load_txn("lw", OP_LW, 32'h0000_1004, 32'h8899_AABB, 32'h8899_AABB);
      load_txn("lb", OP_LB, 32'h0000_2003, 32'h80FF_FF7F, 32'hFFFF_FF80);
      load_txn("lbu", OP_LBU, 32'h0000_2003, 32'h80FF_FF7F, 32'h0000_0080);
      load_txn("lh", OP_LH, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
      load_txn("lhu", OP_LHU, 32'h0000_2000, 32'h1234_F00D, 32'h0000_F00D);

      // Misaligned accesses: exception only, no bus traffic
      auto_slave = 1'b1; log_q.delete();
      tick(); mem_valid = 1'b1; mem_op = OP_SW; mem_aluout = 32'h0000_3002; mem_wdata = 32'h1; #1;
      check_val("ades", {30'd0, adel, ades}, 32'd1);
      check_val("ades_bad_addr", bad_addr, 32'h0000_3002);
      check_val("ades_stall", {31'd0, mem_stall}, 32'd0);
      tick(); mem_op = OP_LH; mem_aluout = 32'h0000_3001; #1;
      check_val("adel", {30'd0, adel, ades}, 32'd2);
      check_val("adel_bad_addr", bad_addr, 32'h0000_3001);
      check_val("adel_stall", {31'd0, mem_stall}, 32'd0);
      check_val("adel_req", {31'd0, data_req}, 32'd0);
      tick(); idle_inputs(); #1;
      repeat (5) begin tick(); #1; end
      check_val("misalign_no_bus", log_q.size(), 32'd0);

      // Five SBs into a 4-deep buffer with addr_ok withheld
      auto_slave = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; log_q.delete();
      for (int i = 0; i < 5; i++) begin
         tick(); mem_valid = 1'b1; mem_op = OP_SB; mem_aluout = sb_addr[i];
         mem_wdata = {24'h123456, sb_byte[i]}; #1;
         check_val($sformatf("sb%0d_stall", i), {31'd0, mem_stall}, {31'd0, sb_stall[i]});
         if (i == 2) begin
            check_val("sb_req", {30'd0, data_req, data_wr}, 32'd3);
            check_val("sb_strb", {28'd0, data_wstrb}, 32'b0100);
            check_val("sb_wdata", data_wdata, 32'hABAB_ABAB);
            check_val("sb_size", {30'd0, data_size}, 32'd0);
         end
      end
      tick(); data_addr_ok = 1'b1; #1;
      check_val("sb_full_stall", {31'd0, mem_stall}, 32'd1);
      check_val("sb_hold_addr", data_addr, 32'h0000_4002);
      tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; #1;
      check_val("sb_deq_stall", {31'd0, mem_stall}, 32'd0);
      tick(); data_data_ok = 1'b0; idle_inputs(); auto_slave = 1'b1; #1;
      drain_until("sb_drain", 5);
      for (int i = 0; i < 5; i++) begin
         if (i < log_q.size()) begin
            check_val($sformatf("sb%0d_log_addr", i), log_q[i].addr, sb_addr[i]);
            check_val($sformatf("sb%0d_log_strb", i), {28'd0, log_q[i].strb}, {28'd0, sb_strb[i]});
            check_val($sformatf("sb%0d_log_data", i), log_q[i].wdata, sb_data[i]);
         end
      end

      // Load after two stores: both writes complete before the read is issued
      repeat (3) begin tick(); #1; end
      log_q.delete(); slave_rdata = 32'h0BAD_F00D;
      tick(); mem_valid = 1'b1; mem_op = OP_SH; mem_aluout = 32'h0000_5002; mem_wdata = 32'h0000_BEEF; #1;
      tick(); mem_op = OP_SW; mem_aluout = 32'h0000_5004; mem_wdata = 32'hDEAD_BEEF; #1;
      tick(); mem_op = OP_LW; mem_aluout = 32'h0000_5004; #1;
      got = 1'b0; res = 32'h0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (mem_rvalid) begin got = 1'b1; res = mem_result; end
         else begin tick(); #1; end
      end
      check_val("ord_rvalid", {31'd0, got}, 32'd1);
      check_val("ord_result", res, 32'h0BAD_F00D);
      tick(); idle_inputs(); #1;
      check_val("ord_count", log_q.size(), 32'd3);
      if (log_q.size() == 3) begin
         check_val("ord_kinds", {29'd0, log_q[0].wr, log_q[1].wr, log_q[2].wr}, 32'b110);
         check_val("sh_strb", {28'd0, log_q[0].strb}, 32'b1100);
         check_val("sh_data", log_q[0].wdata, 32'hBEEF_BEEF);
         check_val("sw_strb", {28'd0, log_q[1].strb}, 32'b1111);
         check_val("rd_addr", log_q[2].addr, 32'h0000_5004);
      end

      // Flush in RD_WAIT: response dropped, a later store still drains
      auto_slave = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      tick(); mem_valid = 1'b1; mem_op = OP_LW; mem_aluout = 32'h0000_6000; #1;
      tick(); data_addr_ok = 1'b1; #1;
      check_val("fl_req", {31'd0, data_req}, 32'd1);
      tick(); data_addr_ok = 1'b0; flush = 1'b1; #1;
      check_val("fl_stall", {31'd0, mem_stall}, 32'd0);
      check_val("fl_rvalid", {31'd0, mem_rvalid}, 32'd0);
      tick(); flush = 1'b0; mem_op = OP_SW; mem_aluout = 32'h0000_7000; mem_wdata = 32'hCAFE_F00D; #1;
      check_val("fl_store_stall", {31'd0, mem_stall}, 32'd0);
      tick(); idle_inputs(); data_data_ok = 1'b1; data_rdata = 32'h1234_5678; #1;
      check_val("drop_rvalid", {31'd0, mem_rvalid}, 32'd0);
      check_val("drop_result", mem_result, 32'd0);
      check_val("drop_req", {31'd0, data_req}, 32'd0);
      tick(); data_data_ok = 1'b0; auto_slave = 1'b1; log_q.delete(); #1;
      drain_until("fl_drain", 1);
      if (log_q.size() >= 1) begin
         check_val("fl_drain_addr", log_q[0].addr, 32'h0000_7000);
         check_val("fl_drain_data", log_q[0].wdata, 32'hCAFE_F00D);
      end

      // A store presented in the flush cycle is not buffered
      repeat (3) begin tick(); #1; end
      log_q.delete();
      tick(); mem_valid = 1'b1; mem_op = OP_SW; mem_aluout = 32'h0000_7100; flush = 1'b1; #1;
      check_val("fl_sw_stall", {31'd0, mem_stall}, 32'd0);
      tick(); idle_inputs(); #1;
      repeat (8) begin tick(); #1; end
      check_val("fl_sw_dropped", log_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
